// File: rtl/stopwatch_lap_if.sv
// Board-side bundle for stopwatch_lap: raw active-low keys in, packed BCD digits and status out.
interface stopwatch_lap_if #(
    parameter int LAP_DEPTH = 4
);
    localparam int PW = $clog2(LAP_DEPTH);

    logic          key_clear;
    logic          key_start_pause;
    logic          key_lap;
    logic [23:0]   digits;
    logic          running;
    logic          recall;
    logic [PW-1:0] lap_idx;
    logic [PW:0]   lap_count;
    logic          overflow;

    modport master (
        output key_clear, key_start_pause, key_lap,
        input  digits, running, recall, lap_idx, lap_count, overflow
    );

    modport slave (
        input  key_clear, key_start_pause, key_lap,
        output digits, running, recall, lap_idx, lap_count, overflow
    );
endinterface

// File: rtl/stopwatch_lap.sv
// MM:SS.cc stopwatch with debounced keys, start/pause, soft clear and a circular lap memory.
// Define STOPWATCH_SATURATE_EN to hold at 59:59.99 instead of wrapping to 00:00.00.
module stopwatch_lap #(
    parameter int TICK_DIV        = 500000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LAP_DEPTH       = 4
) (
    input  logic           clk,
    input  logic           reset,
    stopwatch_lap_if.slave io
);
    localparam int          PW        = $clog2(LAP_DEPTH);
    localparam int          TW        = $clog2(TICK_DIV);
    localparam int          DW        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [23:0] COUNT_MAX = 24'h595999;
    localparam logic [PW:0] LAP_FULL  = (PW+1)'(LAP_DEPTH);
    localparam int          K_LAP     = 0;
    localparam int          K_SP      = 1;
    localparam int          K_CLR     = 2;

    typedef enum logic [1:0] {
        PAUSED_LIVE   = 2'd0,
        RUNNING       = 2'd1,
        PAUSED_RECALL = 2'd2
    } state_e;

    // ---------------- key synchronise + debounce ----------------
    logic [2:0]         key_raw;
    logic [2:0]         sync1_q, sync2_q;
    logic [2:0]         level_q, level_d;
    logic [2:0][DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [2:0]         press;

    assign key_raw = {io.key_clear, io.key_start_pause, io.key_lap};

    // NOTE: every variable gets a default before any branch, so no latches are inferred.
    always_comb begin
        level_d   = level_q;
        deb_cnt_d = '0;
        press     = '0;
        for (int k = 0; k < 3; k++) begin
            if (sync2_q[k] != level_q[k]) begin
                if (deb_cnt_q[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level_d[k] = sync2_q[k];
                    press[k]   = ~sync2_q[k];
                end else begin
                    deb_cnt_d[k] = deb_cnt_q[k] + DW'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            level_q   <= '1;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= key_raw;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // ---------------- count, state and lap memory ----------------
    state_e        state_q, state_d;
    logic [23:0]   count_q, count_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          overflow_q, overflow_d;
    logic [PW-1:0] lap_idx_q, lap_idx_d;
    logic [PW:0]   lap_count_q, lap_count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [23:0]   digits_q, digits_d;
    logic          running_q, recall_q;
    logic          lap_we;
    logic [PW-1:0] rd_ptr;
    logic          tick;
    logic [23:0]   lap_mem_q [LAP_DEPTH];

    function automatic logic [23:0] bcd_inc(input logic [23:0] c);
        logic [23:0] r;
        logic        carry;
        logic [3:0]  lim;
        r     = c;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (carry) begin
                if (r[i*4 +: 4] == lim) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick = (state_q == RUNNING) && (tick_cnt_q == TW'(TICK_DIV - 1));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        tick_cnt_d  = tick_cnt_q;
        overflow_d  = overflow_q;
        lap_idx_d   = lap_idx_q;
        lap_count_d = lap_count_q;
        wr_ptr_d    = wr_ptr_q;
        lap_we      = 1'b0;

        if (state_q == RUNNING) begin
            if (tick) begin
                tick_cnt_d = '0;
                if (count_q == COUNT_MAX) begin
                    overflow_d = 1'b1;
`ifdef STOPWATCH_SATURATE_EN
                    count_d = count_q;
`else
                    count_d = '0;
`endif
                end else begin
                    count_d = bcd_inc(count_q);
                end
            end else begin
                tick_cnt_d = tick_cnt_q + TW'(1);
            end
        end

        // Invalid events (clear while running, lap with empty memory) fall through to lower ones.
        unique case (state_q)
            PAUSED_LIVE: begin
                if (press[K_CLR]) begin
                    count_d     = '0;
                    tick_cnt_d  = '0;
                    overflow_d  = 1'b0;
                    lap_count_d = '0;
                    wr_ptr_d    = '0;
                end else if (press[K_SP]) begin
                    state_d = RUNNING;
                end else if (press[K_LAP] && lap_count_q != '0) begin
                    state_d   = PAUSED_RECALL;
                    lap_idx_d = '0;
                end
            end
            RUNNING: begin
                if (press[K_SP]) begin
                    state_d = PAUSED_LIVE;
                end else if (press[K_LAP]) begin
                    lap_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    if (lap_count_q != LAP_FULL) lap_count_d = lap_count_q + (PW+1)'(1);
                end
            end
            PAUSED_RECALL: begin
                if (press[K_CLR]) begin
                    count_d     = '0;
                    tick_cnt_d  = '0;
                    overflow_d  = 1'b0;
                    lap_count_d = '0;
                    wr_ptr_d    = '0;
                    lap_idx_d   = '0;
                    state_d     = PAUSED_LIVE;
                end else if (press[K_SP]) begin
                    lap_idx_d = '0;
                    state_d   = RUNNING;
                end else if (press[K_LAP]) begin
                    if ({1'b0, lap_idx_q} == lap_count_q - (PW+1)'(1)) begin
                        lap_idx_d = '0;
                        state_d   = PAUSED_LIVE;
                    end else begin
                        lap_idx_d = lap_idx_q + PW'(1);
                    end
                end
            end
            default: state_d = PAUSED_LIVE;
        endcase

        // Oldest surviving entry sits lap_count slots behind the write pointer.
        rd_ptr   = wr_ptr_q - lap_count_q[PW-1:0] + lap_idx_d;
        digits_d = (state_d == PAUSED_RECALL) ? lap_mem_q[rd_ptr] : count_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= PAUSED_LIVE;
            count_q     <= '0;
            tick_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            lap_idx_q   <= '0;
            lap_count_q <= '0;
            wr_ptr_q    <= '0;
            digits_q    <= '0;
            running_q   <= 1'b0;
            recall_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            tick_cnt_q  <= tick_cnt_d;
            overflow_q  <= overflow_d;
            lap_idx_q   <= lap_idx_d;
            lap_count_q <= lap_count_d;
            wr_ptr_q    <= wr_ptr_d;
            digits_q    <= digits_d;
            running_q   <= (state_d == RUNNING);
            recall_q    <= (state_d == PAUSED_RECALL);
        end
    end

    // NOTE: the lap memory is deliberately not reset; lap_count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (lap_we) lap_mem_q[wr_ptr_q] <= count_q;
    end

    assign io.digits    = digits_q;
    assign io.running   = running_q;
    assign io.recall    = recall_q;
    assign io.lap_idx   = lap_idx_q;
    assign io.lap_count = lap_count_q;
    assign io.overflow  = overflow_q;
endmodule

// File: tb/tb_stopwatch_lap.sv
// Randomised and directed bench for stopwatch_lap against a centisecond/queue reference model.
module tb_stopwatch_lap;
    localparam int TICK_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 3;
    localparam int LAP_DEPTH       = 4;
    localparam int MAX_CS          = 359999;

    logic clk = 1'b0;
    logic reset;

    stopwatch_lap_if #(.LAP_DEPTH(LAP_DEPTH)) io ();

    stopwatch_lap #(
        .TICK_DIV       (TICK_DIV),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .LAP_DEPTH      (LAP_DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .io   (io)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: time in whole centiseconds, laps in a queue, keys as delayed samples.
    int  m_cs, m_tick, m_idx;
    bit  m_ovf, m_run, m_rec;
    int  laps[$];
    bit  acc[3];
    int  streak[3];
    bit  r1[3], r2[3];

    function automatic logic [23:0] to_bcd(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic model_clear();
        m_cs = 0; m_tick = 0; m_ovf = 1'b0;
        laps.delete();
    endtask

    task automatic model_reset();
        model_clear();
        m_run = 1'b0; m_rec = 1'b0; m_idx = 0;
        for (int k = 0; k < 3; k++) begin
            acc[k] = 1'b1; streak[k] = 0; r1[k] = 1'b1; r2[k] = 1'b1;
        end
    endtask

    task automatic model_step();
        bit raw[3];
        bit ev[3];
        int pre;
        bit was_run;
        raw[0] = io.key_clear;
        raw[1] = io.key_start_pause;
        raw[2] = io.key_lap;
        for (int k = 0; k < 3; k++) begin
            ev[k] = 1'b0;
            if (r2[k] != acc[k]) streak[k]++;
            else streak[k] = 0;
            if (streak[k] == DEBOUNCE_CYCLES) begin
                acc[k]    = r2[k];
                streak[k] = 0;
                ev[k]     = (acc[k] == 1'b0);
            end
            r2[k] = r1[k];
            r1[k] = raw[k];
        end
        pre     = m_cs;
        was_run = m_run;
        if (was_run) begin
            if (m_tick == TICK_DIV - 1) begin
                m_tick = 0;
                if (m_cs == MAX_CS) begin
                    m_ovf = 1'b1;
`ifndef STOPWATCH_SATURATE_EN
                    m_cs = 0;
`endif
                end else begin
                    m_cs++;
                end
            end else begin
                m_tick++;
            end
        end
        if (m_rec) begin
            if (ev[0]) begin
                model_clear(); m_rec = 1'b0; m_idx = 0;
            end else if (ev[1]) begin
                m_rec = 1'b0; m_run = 1'b1; m_idx = 0;
            end else if (ev[2]) begin
                if (m_idx == laps.size() - 1) begin
                    m_rec = 1'b0; m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
        end else if (was_run) begin
            if (ev[1]) m_run = 1'b0;
            else if (ev[2]) begin
                laps.push_back(pre);
                if (laps.size() > LAP_DEPTH) void'(laps.pop_front());
            end
        end else begin
            if (ev[0]) model_clear();
            else if (ev[1]) m_run = 1'b1;
            else if (ev[2] && laps.size() > 0) begin
                m_rec = 1'b1; m_idx = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("digits", io.digits, m_rec ? to_bcd(laps[m_idx]) : to_bcd(m_cs));
        check("running", io.running, m_run);
        check("recall", io.recall, m_rec);
        check("lap_idx", io.lap_idx, m_idx);
        check("lap_count", io.lap_count, laps.size());
        check("overflow", io.overflow, m_ovf);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_keys(input bit c, input bit s, input bit l);
        io.key_clear       = ~c;
        io.key_start_pause = ~s;
        io.key_lap         = ~l;
    endtask

    task automatic press(input bit c, input bit s, input bit l);
        set_keys(c, s, l);
        repeat (4) cycle();
        set_keys(1'b0, 1'b0, 1'b0);
        repeat (6) cycle();
    endtask

    task automatic wait_running();
        int n;
        n = 0;
        while (!io.running && n < 20) begin
            cycle();
            n++;
        end
        check("running_timeout", io.running, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_digits"}, io.digits, 24'h0);
        check({tag, "_running"}, io.running, 1'b0);
        check({tag, "_recall"}, io.recall, 1'b0);
        check({tag, "_lap_idx"}, io.lap_idx, 0);
        check({tag, "_lap_count"}, io.lap_count, 0);
        check({tag, "_overflow"}, io.overflow, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_keys(1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("por");
        reset = 1'b0;

        // Two-cycle glitch must not be accepted.
        io.key_start_pause = 1'b0;
        repeat (2) cycle();
        io.key_start_pause = 1'b1;
        repeat (6) cycle();
        check("glitch_running", io.running, 1'b0);

        // Real press: accepted 3 + 2 synchroniser cycles after the fall.
        io.key_start_pause = 1'b0;
        repeat (4) cycle();
        check("start_early", io.running, 1'b0);
        cycle();
        check("start_exact", io.running, 1'b1);
        io.key_start_pause = 1'b1;
        repeat (40) cycle();
        check("run_40", io.digits, 24'h000010);

        // Wrap (or saturate) from 59:59.99.
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check("clear_digits", io.digits, 24'h0);
        force dut.count_q = 24'h595999;
        m_cs = MAX_CS;
        cycle();
        release dut.count_q;
        io.key_start_pause = 1'b0;
        wait_running();
        io.key_start_pause = 1'b1;
        repeat (3) cycle();
        check("pre_wrap", io.digits, 24'h595999);
        cycle();
`ifdef STOPWATCH_SATURATE_EN
        check("sat_digits", io.digits, 24'h595999);
        check("sat_running", io.running, 1'b1);
`else
        check("wrap_digits", io.digits, 24'h000000);
`endif
        check("wrap_overflow", io.overflow, 1'b1);

        // Lap captured on the same edge as the 7 -> 8 tick.
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check("clear_overflow", io.overflow, 1'b0);
        io.key_start_pause = 1'b0;
        wait_running();
        io.key_start_pause = 1'b1;
        repeat (27) cycle();
        io.key_lap = 1'b0;
        repeat (5) cycle();
        check("tick_lap_live", io.digits, 24'h000008);
        check("tick_lap_count", io.lap_count, 1);
        io.key_lap = 1'b1;
        repeat (6) cycle();

        // Five laps into a four-deep buffer, then recall all of them.
        repeat (4) press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        check("laps_full", io.lap_count, LAP_DEPTH);
        for (int i = 0; i < LAP_DEPTH; i++) begin
            press(1'b0, 1'b0, 1'b1);
            check("recall_on", io.recall, 1'b1);
            check("recall_idx", io.lap_idx, i);
            if (i == 0) check("oldest_dropped", io.digits == 24'h000007, 1'b0);
        end
        press(1'b0, 1'b0, 1'b1);
        check("recall_exit", io.recall, 1'b0);
        check("recall_exit_idx", io.lap_idx, 0);

        // Clear + start_pause together: running ignores clear, paused honours it.
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        check("pair_run_running", io.running, 1'b0);
        check("pair_run_laps", io.lap_count, LAP_DEPTH);
        press(1'b1, 1'b1, 1'b0);
        check("pair_pause_digits", io.digits, 24'h0);
        check("pair_pause_laps", io.lap_count, 0);
        check("pair_pause_running", io.running, 1'b0);

        // Random key activity.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(11) == 0) io.key_clear = ~io.key_clear;
            if ($urandom_range(5) == 0) io.key_start_pause = ~io.key_start_pause;
            if ($urandom_range(4) == 0) io.key_lap = ~io.key_lap;
            cycle();
        end

        // Asynchronous reset between clock edges.
        #2 reset = 1'b1;
        #1 check_all_zero("async_rst");
        set_keys(1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) cycle();
        reset = 1'b0;
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
